// File: rtl/digpot_seq_pkg.sv
// Shared encodings for the three-wire digital pot sequencer.
// Position width, pin idle levels and FSM states live here.
package digpot_seq_pkg;

  localparam int POS_W  = 7;
  localparam int STEP_W = POS_W + 1;

  localparam logic CS_IDLE  = 1'b1;
  localparam logic INC_IDLE = 1'b1;
  localparam logic UD_IDLE  = 1'b0;

  typedef enum logic [2:0] {
    S_HOME,
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_STORE_HI,
    S_STORE,
    S_DESEL
  } dp_state_e;

  function automatic logic [POS_W-1:0] clamp_pos(
    input logic [POS_W-1:0] t,
    input logic [POS_W-1:0] lim
  );
    return (t > lim) ? lim : t;
  endfunction

endpackage

// File: rtl/digpot_seq_if.sv
// Request handshake between the bus side and the pot sequencer.
// The bus side is the master; the sequencer is the slave.
interface digpot_seq_if;
  import digpot_seq_pkg::*;

  logic             req_valid;
  logic [POS_W-1:0] req_target;
  logic             req_store;
  logic             req_ready;

  modport master (
    output req_valid,
    output req_target,
    output req_store,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_target,
    input  req_store,
    output req_ready
  );

endinterface

// File: rtl/digpot_timer.sv
// Loadable dwell counter for the pot sequencer states.
// The load strobe is registered, so the count starts one cycle late.
module digpot_timer #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expired
);

  logic [W-1:0] cnt;

  // len-2 absorbs the registered load cycle and the expiry cycle
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len - W'(2);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0) & ~load;

endmodule

// File: rtl/digpot_seq.sv
// Wiper sequencer: homes the pot, then steps it to requested taps
// with divider-timed CS#/U/D/INC# pulses and optional store.
module digpot_seq
  import digpot_seq_pkg::*;
#(
  parameter int CLK_DIV   = 50,
  parameter int WIPER_MAX = 99,
  parameter int STORE_CYC = 1000
) (
  input  logic             clk_in,
  input  logic             reset,
  digpot_seq_if.slave      req,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] wiper_pos,
  output logic             dp_cs_n,
  output logic             dp_inc_n,
  output logic             dp_ud
);

  localparam int DW_MAX =
    (CLK_DIV > STORE_CYC) ? CLK_DIV : STORE_CYC;
  localparam int TW = $clog2(DW_MAX) + 1;

  localparam logic [TW-1:0] T_DIV = TW'(CLK_DIV);
  localparam logic [TW-1:0] T_STO = TW'(STORE_CYC);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(WIPER_MAX);
  localparam logic [STEP_W-1:0] HOME_STEPS =
    STEP_W'(WIPER_MAX + 1);

  dp_state_e         state;
  logic              ready;
  logic              dir;
  logic              store;
  logic [STEP_W-1:0] steps;
  logic              t_load;
  logic [TW-1:0]     t_len;
  logic              t_exp;

  logic [POS_W-1:0]  tgt;
  logic              acc_dir;
  logic [STEP_W-1:0] acc_steps;
  logic              accept;
  logic [POS_W-1:0]  pos_nxt;

  assign req.req_ready = ready;
  assign accept = req.req_valid & ready;

  assign tgt     = clamp_pos(req.req_target, P_MAX);
  assign acc_dir = tgt > wiper_pos;
  assign acc_steps = acc_dir
    ? STEP_W'(tgt - wiper_pos)
    : STEP_W'(wiper_pos - tgt);

  // Saturating step; homing leans on the low clamp
  always_comb begin
    pos_nxt = wiper_pos;
    unique case (1'b1)
      dir && (wiper_pos != P_MAX):
        pos_nxt = wiper_pos + POS_W'(1);
      !dir && (wiper_pos != '0):
        pos_nxt = wiper_pos - POS_W'(1);
      default: ;
    endcase
  end

  digpot_timer #(
    .W (TW)
  ) u_timer (
    .clk_in  (clk_in),
    .reset   (reset),
    .load    (t_load),
    .len     (t_len),
    .expired (t_exp)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state     <= S_HOME;
      dp_cs_n   <= CS_IDLE;
      dp_inc_n  <= INC_IDLE;
      dp_ud     <= UD_IDLE;
      ready     <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      wiper_pos <= '0;
      steps     <= '0;
      dir       <= 1'b0;
      store     <= 1'b0;
      t_load    <= 1'b0;
      t_len     <= '0;
    end else begin
      done   <= 1'b0;
      t_load <= 1'b0;
      unique case (state)
        S_HOME: begin
          dir       <= 1'b0;
          store     <= 1'b0;
          steps     <= HOME_STEPS;
          wiper_pos <= '0;
          dp_cs_n   <= 1'b0;
          dp_ud     <= 1'b0;
          dp_inc_n  <= 1'b1;
          t_load    <= 1'b1;
          t_len     <= T_DIV;
          state     <= S_SETUP;
        end
        S_IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            ready <= 1'b0;
            steps <= acc_steps;
            dir   <= acc_dir;
            store <= req.req_store;
            if (acc_steps == '0 && !req.req_store) begin
              done <= 1'b1;
            end else begin
              busy    <= 1'b1;
              dp_cs_n <= 1'b0;
              dp_ud   <= acc_dir;
              t_load  <= 1'b1;
              t_len   <= T_DIV;
              state   <= S_SETUP;
            end
          end
        end
        S_SETUP, S_HIGH: begin
          if (t_exp) begin
            t_load <= 1'b1;
            t_len  <= T_DIV;
            if (steps != '0) begin
              dp_inc_n  <= 1'b0;
              wiper_pos <= pos_nxt;
              steps     <= steps - STEP_W'(1);
              state     <= S_LOW;
            end else begin
              state <= S_STORE_HI;
            end
          end
        end
        S_LOW: begin
          if (t_exp) begin
            t_load <= 1'b1;
            t_len  <= T_DIV;
            if (steps != '0) begin
              dp_inc_n <= 1'b1;
              state    <= S_HIGH;
            end else if (store) begin
              dp_inc_n <= 1'b1;
              state    <= S_STORE_HI;
            end else begin
              dp_cs_n <= 1'b1;
              state   <= S_DESEL;
            end
          end
        end
        S_STORE_HI: begin
          if (t_exp) begin
            dp_cs_n <= 1'b1;
            t_load  <= 1'b1;
            t_len   <= T_STO;
            state   <= S_STORE;
          end
        end
        S_STORE: begin
          if (t_exp) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DESEL: begin
          if (t_exp) begin
            dp_inc_n <= 1'b1;
            busy     <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digpot_seq.sv
// Scoreboard bench for digpot_seq: expected moves are queued at
// issue time and checked by a pin/done monitor.
module tb_digpot_seq;

  localparam int D  = 4;
  localparam int WM = 99;
  localparam int SC = 20;

  typedef struct {
    int t0;
    int start;
    int pos;
    int n;
    bit ud;
    bit st;
    int acc;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       done;
  logic       cs_n;
  logic       inc_n;
  logic       ud;
  logic [6:0] pos;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int   n_fall   = 0;
  int   cs_fall  = -1;
  int   cs_rise  = -1;
  int   rule_bad = 0;
  int   n_acc    = 0;
  logic inc_at_rise = 1'b0;
  logic pcs  = 1'b1;
  logic pinc = 1'b1;
  logic pud  = 1'b0;

  digpot_seq_if ifc();

  digpot_seq #(
    .CLK_DIV   (D),
    .WIPER_MAX (WM),
    .STORE_CYC (SC)
  ) dut (
    .clk_in    (clk),
    .reset     (rst_n),
    .req       (ifc.slave),
    .busy      (busy),
    .done      (done),
    .wiper_pos (pos),
    .dp_cs_n   (cs_n),
    .dp_inc_n  (inc_n),
    .dp_ud     (ud)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp_v, cyc);
    end
  endtask

  function automatic int step_pos(exp_t e, int k);
    int p;
    p = e.ud ? e.start + k : e.start - k;
    if (p > WM) p = WM;
    if (p < 0) p = 0;
    return p;
  endfunction

  function automatic int exp_rise(exp_t e);
    if (e.n == 0) return e.st ? 1 + 2 * D : -1;
    return e.st ? 1 + 2 * D * e.n + D : 1 + 2 * D * e.n;
  endfunction

  function automatic int exp_done(exp_t e);
    if (e.n == 0 && !e.st) return 1;
    return e.st ? exp_rise(e) + SC : exp_rise(e) + D;
  endfunction

  task automatic clr();
    n_fall   = 0;
    cs_fall  = -1;
    cs_rise  = -1;
    rule_bad = 0;
    n_acc    = 0;
  endtask

  initial begin : mon
    int   rel;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clr();
      end else begin
        rel = (sb.size() > 0) ? cyc - sb[0].t0 : -1;
        if (pcs && !cs_n) cs_fall = rel;
        if (!pcs && cs_n) begin
          cs_rise     = rel;
          inc_at_rise = inc_n;
        end
        if (pinc && !inc_n && !cs_n) begin
          if (sb.size() > 0) begin
            e = sb[0];
            chk("fall_time", rel, 1 + D + 2 * D * n_fall);
            chk("fall_pos", pos, step_pos(e, n_fall + 1));
            chk("fall_ud", ud, e.ud);
          end
          n_fall++;
        end
        if (cs_n !== pcs && inc_n !== pinc) rule_bad++;
        if (ud !== pud && !cs_n && !pcs) rule_bad++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("done_time", rel, exp_done(e));
            chk("pos", pos, e.pos);
            chk("falls", n_fall, e.n);
            chk("cs_fall", cs_fall,
                (e.n == 0 && !e.st) ? -1 : 1);
            chk("cs_rise", cs_rise, exp_rise(e));
            if (exp_rise(e) >= 0)
              chk("inc_at_cs_rise", inc_at_rise, e.st);
            chk("pin_rules", rule_bad, 0);
            chk("accepts", n_acc, e.acc);
          end
          clr();
        end
        if (ifc.req_valid && ifc.req_ready) n_acc++;
      end
      pcs  = cs_n;
      pinc = inc_n;
      pud  = ud;
    end
  end

  task automatic wait_sb(input bit hold);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (hold && !busy) ifc.req_valid = 1'b0;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !ifc.req_ready; i++) begin
      @(posedge clk);
      #2;
    end
    chk("ready_before_req", ifc.req_ready, 1);
  endtask

  task automatic home();
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    e = '{t0: cyc, start: 0, pos: 0, n: WM + 1,
          ud: 1'b0, st: 1'b0, acc: 0};
    sb.push_back(e);
    wait_sb(1'b0);
    chk("ready_after_home", ifc.req_ready, 1);
  endtask

  task automatic do_req(input logic [6:0] tgt, input bit st,
                        input int start, input int p,
                        input int n, input bit up,
                        input bit hold);
    exp_t e;
    wait_ready();
    ifc.req_valid  = 1'b1;
    ifc.req_target = tgt;
    ifc.req_store  = st;
    @(negedge clk);
    e = '{t0: cyc, start: start, pos: p, n: n,
          ud: up, st: st, acc: 1};
    sb.push_back(e);
    if (!hold) begin
      @(posedge clk);
      #2;
      ifc.req_valid = 1'b0;
    end
    wait_sb(hold);
  endtask

  initial begin : stim
    ifc.req_valid  = 1'b0;
    ifc.req_target = '0;
    ifc.req_store  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_inc_n", inc_n, 1);
    chk("rst_ud", ud, 0);
    chk("rst_ready", ifc.req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_pos", pos, 0);

    home();
    do_req(7'd3,   1'b0, 0,  3,  3,  1'b1, 1'b0);
    do_req(7'd1,   1'b1, 3,  1,  2,  1'b0, 1'b0);
    do_req(7'd120, 1'b0, 1,  99, 98, 1'b1, 1'b0);
    do_req(7'd99,  1'b0, 99, 99, 0,  1'b0, 1'b0);
    do_req(7'd99,  1'b1, 99, 99, 0,  1'b0, 1'b0);
    do_req(7'd95,  1'b0, 99, 95, 4,  1'b0, 1'b1);
    do_req(7'd97,  1'b1, 95, 97, 2,  1'b1, 1'b0);

    // 10-step move cut short by reset after its second fall
    wait_ready();
    ifc.req_valid  = 1'b1;
    ifc.req_target = 7'd87;
    ifc.req_store  = 1'b0;
    @(posedge clk);
    #2;
    ifc.req_valid = 1'b0;
    for (int i = 0; i < 100 && n_fall < 2; i++) begin
      @(posedge clk);
      #2;
    end
    chk("abort_falls", n_fall, 2);
    chk("abort_pos", pos, 95);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_inc_n", inc_n, 1);
    chk("abort_busy", busy, 1);
    chk("abort_ready", ifc.req_ready, 0);
    chk("abort_pos_rst", pos, 0);
    home();
    do_req(7'd2, 1'b0, 0, 2, 2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
